// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection.
// A load in EX whose destination is read by the instruction in ID stalls
// PC and IF/ID for one cycle and injects a bubble into EX.
// Optional: define STALL_COUNT_EN to count hazard bubbles in stall_count
// (saturating); otherwise stall_count is tied to 0.
module id_ex_stage #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_ID,
  input  logic [4:0]    rs_ID,
  input  logic [4:0]    rt_ID,
  input  logic [4:0]    rd_ID,
  input  logic          uses_rs_ID,
  input  logic          uses_rt_ID,
  input  logic [DW-1:0] reg_a_ID,
  input  logic [DW-1:0] reg_b_ID,
  input  logic [DW-1:0] imm_ID,
  input  logic          mem_read_ID,
  input  logic          mem_write_ID,
  input  logic          write_reg_ID,
  input  logic          reg_dst_ID,
  input  logic          alu_src_ID,
  input  logic [3:0]    alu_op_ID,
  input  logic          flush_EX,
  output logic          valid_EX,
  output logic          mem_read_EX,
  output logic          mem_write_EX,
  output logic          write_reg_EX,
  output logic          alu_src_EX,
  output logic [3:0]    alu_op_EX,
  output logic [4:0]    rs_EX,
  output logic [4:0]    rt_EX,
  output logic [4:0]    rw_EX,
  output logic [DW-1:0] reg_a_EX,
  output logic [DW-1:0] reg_b_EX,
  output logic [DW-1:0] imm_EX,
  output logic          pc_write,
  output logic          if_id_write,
  output logic [DW-1:0] stall_count
);

  typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} state_t;

  state_t state_q, state_d;
  logic   hazard;
  logic   bubble;
  logic   rs_hit, rt_hit;

  // Load in EX feeding a source of the ID instruction; r0 loads never stall.
  always_comb begin
    rs_hit = uses_rs_ID & (rw_EX == rs_ID);
    rt_hit = uses_rt_ID & (rw_EX == rt_ID);
    hazard = valid_ID & ~flush_EX & valid_EX & mem_read_EX & (rw_EX != 5'd0) &
             (rs_hit | rt_hit) & (state_q == RUN);
    bubble = flush_EX | hazard | ~valid_ID;
  end

  assign pc_write    = ~hazard;
  assign if_id_write = ~hazard;

  // State register: BUBBLE marks the single stall cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next state: a stall lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (hazard) state_d = BUBBLE;
      BUBBLE:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Pipeline register: bubble clears control and register numbers, data rides along.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_EX     <= 1'b0;
      mem_read_EX  <= 1'b0;
      mem_write_EX <= 1'b0;
      write_reg_EX <= 1'b0;
      alu_src_EX   <= 1'b0;
      alu_op_EX    <= '0;
      rs_EX        <= '0;
      rt_EX        <= '0;
      rw_EX        <= '0;
      reg_a_EX     <= '0;
      reg_b_EX     <= '0;
      imm_EX       <= '0;
    end else begin
      reg_a_EX <= reg_a_ID;
      reg_b_EX <= reg_b_ID;
      imm_EX   <= imm_ID;
      if (bubble) begin
        valid_EX     <= 1'b0;
        mem_read_EX  <= 1'b0;
        mem_write_EX <= 1'b0;
        write_reg_EX <= 1'b0;
        alu_src_EX   <= 1'b0;
        alu_op_EX    <= '0;
        rs_EX        <= '0;
        rt_EX        <= '0;
        rw_EX        <= '0;
      end else begin
        valid_EX     <= 1'b1;
        mem_read_EX  <= mem_read_ID;
        mem_write_EX <= mem_write_ID;
        write_reg_EX <= write_reg_ID;
        alu_src_EX   <= alu_src_ID;
        alu_op_EX    <= alu_op_ID;
        rs_EX        <= rs_ID;
        rt_EX        <= rt_ID;
        rw_EX        <= reg_dst_ID ? rd_ID : rt_ID;
      end
    end
  end

`ifdef STALL_COUNT_EN
  logic [DW-1:0] stall_cnt_q;

  // Count hazard bubbles only; saturate instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         stall_cnt_q <= '0;
    else if (hazard && ~&stall_cnt_q)   stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load-use stall, false-stall
// cases, flush priority, rw_EX select, stores, counter, reset mid-stall.
module tb_id_ex_stage;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_ID;
  logic [4:0]    rs_ID, rt_ID, rd_ID;
  logic          uses_rs_ID, uses_rt_ID;
  logic [DW-1:0] reg_a_ID, reg_b_ID, imm_ID;
  logic          mem_read_ID, mem_write_ID, write_reg_ID, reg_dst_ID, alu_src_ID;
  logic [3:0]    alu_op_ID;
  logic          flush_EX;
  logic          valid_EX, mem_read_EX, mem_write_EX, write_reg_EX, alu_src_EX;
  logic [3:0]    alu_op_EX;
  logic [4:0]    rs_EX, rt_EX, rw_EX;
  logic [DW-1:0] reg_a_EX, reg_b_EX, imm_EX;
  logic          pc_write, if_id_write;
  logic [DW-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .valid_ID(valid_ID),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .rd_ID(rd_ID),
    .uses_rs_ID(uses_rs_ID), .uses_rt_ID(uses_rt_ID),
    .reg_a_ID(reg_a_ID), .reg_b_ID(reg_b_ID), .imm_ID(imm_ID),
    .mem_read_ID(mem_read_ID), .mem_write_ID(mem_write_ID),
    .write_reg_ID(write_reg_ID), .reg_dst_ID(reg_dst_ID),
    .alu_src_ID(alu_src_ID), .alu_op_ID(alu_op_ID), .flush_EX(flush_EX),
    .valid_EX(valid_EX), .mem_read_EX(mem_read_EX), .mem_write_EX(mem_write_EX),
    .write_reg_EX(write_reg_EX), .alu_src_EX(alu_src_EX), .alu_op_EX(alu_op_EX),
    .rs_EX(rs_EX), .rt_EX(rt_EX), .rw_EX(rw_EX),
    .reg_a_EX(reg_a_EX), .reg_b_EX(reg_b_EX), .imm_EX(imm_EX),
    .pc_write(pc_write), .if_id_write(if_id_write), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one ID instruction (all other inputs idle).
  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic urs, input logic urt,
                       input logic mr, input logic mw, input logic wr, input logic dst);
    valid_ID = v; rs_ID = rs; rt_ID = rt; rd_ID = rd;
    uses_rs_ID = urs; uses_rt_ID = urt;
    mem_read_ID = mr; mem_write_ID = mw; write_reg_ID = wr; reg_dst_ID = dst;
    alu_src_ID = 1'b0; alu_op_ID = 4'h0; flush_EX = 1'b0;
    reg_a_ID = '0; reg_b_ID = '0; imm_ID = '0;
  endtask

  // lw rT <- 0(r1)
  task automatic drive_lw(input logic [4:0] rt);
    drive(1'b1, 5'd1, rt, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_ID = 1'($urandom); rs_ID = 5'($urandom); rt_ID = 5'($urandom);
      rd_ID = 5'($urandom); uses_rs_ID = 1'($urandom); uses_rt_ID = 1'($urandom);
      reg_a_ID = $urandom; reg_b_ID = $urandom; imm_ID = $urandom;
      mem_read_ID = 1'($urandom); mem_write_ID = 1'($urandom);
      write_reg_ID = 1'($urandom); reg_dst_ID = 1'($urandom);
      alu_src_ID = 1'($urandom); alu_op_ID = 4'($urandom); flush_EX = 1'($urandom);
      @(negedge clk);
    end
    check("rst_valid_EX", 32'(valid_EX), 32'd0);
    check("rst_mem_read_EX", 32'(mem_read_EX), 32'd0);
    check("rst_rw_EX", 32'(rw_EX), 32'd0);
    check("rst_reg_a_EX", reg_a_EX, 32'd0);
    check("rst_imm_EX", imm_EX, 32'd0);
    check("rst_pc_write", 32'(pc_write), 32'd1);
    check("rst_if_id_write", 32'(if_id_write), 32'd1);
    check("rst_stall_count", stall_count, 32'd0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Load-use: lw r5 ; add r6, r5, r7
    drive_lw(5'd5); step();
    check("lu_mem_read_EX", 32'(mem_read_EX), 32'd1);
    check("lu_rw_EX", 32'(rw_EX), 32'd5);
    drive(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1); #1;
    check("lu_pc_write", 32'(pc_write), 32'd0);
    check("lu_if_id_write", 32'(if_id_write), 32'd0);
    step();
    check("lu_bubble_valid", 32'(valid_EX), 32'd0);
    check("lu_bubble_wr", 32'(write_reg_EX), 32'd0);
    check("lu_no_second_stall", 32'(pc_write), 32'd1);
    step();
    check("lu_cap_valid", 32'(valid_EX), 32'd1);
    check("lu_cap_rs", 32'(rs_EX), 32'd5);
    check("lu_cap_rw", 32'(rw_EX), 32'd6);

    // lw r0 then use of r0: no stall
    drive_lw(5'd0); step();
    drive(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1); #1;
    check("r0_no_stall", 32'(pc_write), 32'd1);
    step();

    // lw r5 ; addi r6, r5 (rs only) -> stall
    drive_lw(5'd5); step();
    drive(1'b1, 5'd5, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
    check("addi_rs_stall", 32'(pc_write), 32'd0);
    step(); step();
    check("addi_rs_cap_rw", 32'(rw_EX), 32'd6);

    // lw r5 ; addi rt=5 but rt not read, rs=4 -> no stall
    drive_lw(5'd5); step();
    drive(1'b1, 5'd4, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
    check("addi_rs4_no_stall", 32'(pc_write), 32'd1);
    step();
    check("addi_rs4_captured", 32'(valid_EX), 32'd1);

    // Flush beats hazard
    drive_lw(5'd5); step();
    drive(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    flush_EX = 1'b1; #1;
    check("flush_pc_write", 32'(pc_write), 32'd1);
    check("flush_if_id_write", 32'(if_id_write), 32'd1);
    step();
    check("flush_bubble_valid", 32'(valid_EX), 32'd0);
    check("flush_bubble_rw", 32'(rw_EX), 32'd0);
    flush_EX = 1'b0;

    // Store reading data via rt stalls
    drive_lw(5'd5); step();
    drive(1'b1, 5'd2, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); #1;
    check("sw_stall", 32'(pc_write), 32'd0);
    step(); step();
    check("sw_cap_mem_write", 32'(mem_write_EX), 32'd1);
    check("sw_cap_rt", 32'(rt_EX), 32'd5);

    // rw_EX select and data capture
    drive(1'b1, 5'd2, 5'd3, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    alu_op_ID = 4'hA; alu_src_ID = 1'b1;
    reg_a_ID = 32'h1234_5678; reg_b_ID = 32'hCAFE_0001; imm_ID = 32'hFFFF_FFF0;
    step();
    check("rw_sel_rd", 32'(rw_EX), 32'd9);
    check("cap_alu_op", 32'(alu_op_EX), 32'hA);
    check("cap_alu_src", 32'(alu_src_EX), 32'd1);
    check("cap_reg_a", reg_a_EX, 32'h1234_5678);
    check("cap_reg_b", reg_b_EX, 32'hCAFE_0001);
    check("cap_imm", imm_EX, 32'hFFFF_FFF0);
    reg_dst_ID = 1'b0; step();
    check("rw_sel_rt", 32'(rw_EX), 32'd3);

    // Invalid ID -> bubble
    valid_ID = 1'b0; step();
    check("inv_valid_EX", 32'(valid_EX), 32'd0);
    check("inv_rt_EX", 32'(rt_EX), 32'd0);
    check("inv_write_reg", 32'(write_reg_EX), 32'd0);

    // Three hazard stalls so far (load-use, addi, store)
`ifdef STALL_COUNT_EN
    check("cnt_three", stall_count, 32'd3);
    force dut.stall_cnt_q = '1;
    @(negedge clk);
    release dut.stall_cnt_q;
    drive_lw(5'd5); step();
    drive(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(); step();
    check("cnt_saturate", stall_count, 32'hFFFF_FFFF);
`else
    check("cnt_tied_zero", stall_count, 32'd0);
`endif

    // Reset asserted during a stall
    drive_lw(5'd5); step();
    drive(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1); #1;
    check("mid_pre_stall", 32'(pc_write), 32'd0);
    rst_n = 1'b0; #1;
    check("mid_rst_pc_write", 32'(pc_write), 32'd1);
    check("mid_rst_valid_EX", 32'(valid_EX), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("mid_redecode", 32'(rs_EX), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
